seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Sequential display driver for four 7-segment digits sharing one common-anode segment bus.
- Takes four 4-bit BCD digit codes and drives them with an internal decoder, a refresh prescaler and a digit-scan FSM.
- Drives one shared segment/dp bus and four active-low anode enables.
- Sits between the counter/datapath (built from the gate primitives) and the board display pins.

Parameters:
- CLK_DIV, 50000, clock cycles each digit is lit per scan slot; legal range 2..2^20; simulation uses 4.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- en  in  1  scan enable; low blanks the display and restarts the frame
- digits_in  in  16  digit codes; [3:0]=digit0 (rightmost) .. [15:12]=digit3
- dp_in  in  4  decimal point request per digit, 1=on
- blank_in  in  4  per-digit blank, 1=digit dark
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_out  out  1  decimal point, active-low
- an_out  out  4  anode enables, active-low, bit i = digit i
- digit_idx  out  2  digit currently addressed
- frame_done  out  1  one-cycle pulse on the first lit cycle of digit0 of each frame

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous: rst_n low at an edge forces the reset state, regardless of en.
- Reset state: state=LOAD, idx=0, cnt=0, snapshot regs=0, frame_done=0.
- Outputs while in reset or in LOAD/GAP: an_out=4'hF, seg_out=7'h7F, dp_out=1, digit_idx=idx.
- FSM states: LOAD, SHOW, GAP.
  - LOAD: capture digits_in/dp_in/blank_in into snapshot; idx<=0; cnt<=0; next SHOW; frame_done<=1.
  - SHOW: an_out = ~(4'b1<<idx); seg_out/dp_out from snapshot[idx]; cnt increments.
    - When cnt==CLK_DIV-1: cnt<=0; next GAP.
    - frame_done<=0 after its single cycle.
  - GAP (exactly 1 cycle, all anodes off, anti-ghosting dead time):
    - idx<3: idx<=idx+1; next SHOW.
    - idx==3: snapshot recaptured; idx<=0; frame_done<=1; next SHOW.
- Timing:
  - Slot length is CLK_DIV+1 cycles (CLK_DIV lit + 1 GAP).
  - Steady-state frame length is 4*(CLK_DIV+1) cycles.
  - The first frame after reset or enable is 1 cycle longer because of LOAD.
- Inputs are sampled only at snapshot points, so mid-frame input changes never tear a frame. Latency from an input change to display is at most one frame + 1 cycle.
- Decode (active-high before inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 display dash (g only, 40).
- blank_in[i]=1: seg_out=7'h7F and dp_out=1 during slot i. The anode is still asserted, so timing is unchanged.
- en low at an edge: next state LOAD with idx=0, cnt=0; outputs are blanked combinationally in the same cycle. en held low keeps the FSM in LOAD and blanked. The first SHOW follows the first edge with en high.
- Only one bit of an_out is ever low, and only in SHOW.
- cnt width: clog2(CLK_DIV); no overflow past CLK_DIV-1.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: at each snapshot, zero digits from digit3 downward up to the first non-zero digit are marked blank, in addition to blank_in.
  - digit0 is never auto-blanked.
  - A digit with its dp_in set stops the suppression; that digit and all lower digits display normally.
- Undefined: only blank_in controls blanking; zeros always display.

Test Plan (CLK_DIV=4):
- Reset then rst_n=1, en=1, digits_in=16'h1234, dp_in=0, blank_in=0:
  - LOAD for 1 cycle.
  - an_out=4'hE with seg_out=7'h19 (digit "4") for 4 cycles; frame_done=1 only on the first of them.
  - GAP an_out=4'hF for 1 cycle.
  - an_out=4'hD with seg_out=7'h30 ("3").
  - Order continues 3, 2, 1; frame_done recurs every 20 cycles.
- Change digits_in to 16'h5678 mid-digit1: remainder of the frame still shows 3, 2, 1. The next frame shows digit0 seg_out=7'h00 ("8").
- digits_in=16'hF00A, blank_in=4'b0100, dp_in=4'b0001:
  - digit0 seg_out=7'h3F (dash), dp_out=0.
  - digit2 slot: an_out=4'hB, seg_out=7'h7F.
  - digit3 slot: seg_out=7'h3F (dash).
- en dropped during digit2: next cycle an_out=4'hF; held low 10 cycles → stays blank. On restore, LOAD then digit0 with frame_done=1.
- rst_n low for 1 cycle during SHOW digit3: the following cycle has an_out=4'hF, frame_done=0, digit_idx=0. Restart then matches the first scenario.
- With SEG7_LEADING_ZERO_BLANK_EN, digits_in=16'h0040:
  - digits 3 and 2 are blank.
  - digit1 shows "4" (7'h19); digit0 shows "0" (7'h40).
  - With dp_in=4'b0100 instead: digit3 is blank; digit2 shows "0" with dp_out=0.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Bundles the digit request inputs and the multiplexed display outputs of
// seg7_scan_driver. The driver connects through the slave modport, and the
// datapath/bench side connects through the master modport.
interface seg7_scan_driver_if;
    logic        en;          // scan enable; low blanks and restarts the frame
    logic [15:0] digits_in;   // [3:0]=digit0 (rightmost) .. [15:12]=digit3
    logic [3:0]  dp_in;       // decimal point request per digit, 1=on
    logic [3:0]  blank_in;    // per-digit blank, 1=dark
    logic [6:0]  seg_out;     // {g,f,e,d,c,b,a}, active-low
    logic        dp_out;      // decimal point, active-low
    logic [3:0]  an_out;      // anode enables, active-low
    logic [1:0]  digit_idx;   // digit currently addressed
    logic        frame_done;  // pulse on the first lit cycle of each frame

    modport master (
        output en, digits_in, dp_in, blank_in,
        input  seg_out, dp_out, an_out, digit_idx, frame_done
    );

    modport slave (
        input  en, digits_in, dp_in, blank_in,
        output seg_out, dp_out, an_out, digit_idx, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver.
// The driver snapshots the digit codes once per frame. It lights each digit
// for CLK_DIV cycles and inserts one dark GAP cycle between digits to stop
// ghosting.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros at each
// snapshot. A digit with its decimal point set stops the suppression, and
// digit0 is never blanked this way.
module seg7_scan_driver #(
    parameter int CLK_DIV = 50000
) (
    input logic            clk,
    input logic            rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      digits_q;
    logic [3:0]       dp_q;
    logic [3:0]       blank_q;
    logic             frame_done_q;
    logic [3:0]       cap_blank;

    // Active-high segment pattern for one digit code; codes 10..15 show a dash.
    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // Blank mask captured at each snapshot point (blank_in plus optional leading-zero suppression).
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path infers a latch.
        cap_blank = bus.blank_in;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin : lz_scan
            logic suppress;
            suppress = 1'b1;
            for (int i = 3; i >= 1; i--) begin
                if (suppress && (bus.digits_in[4*i +: 4] == 4'd0) && !bus.dp_in[i]) begin
                    cap_blank[i] = 1'b1;
                end else begin
                    suppress = 1'b0;
                end
            end
        end
`endif
    end

    // Scan FSM: LOAD snapshots once, then SHOW/GAP alternate for each digit and resnapshot after digit3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: use non-blocking assignments for all registered state so every
            // update sees pre-edge values. The snapshot registers are also reset,
            // even though LOAD overwrites them before use, which keeps idle state deterministic.
            state        <= ST_LOAD;
            idx          <= 2'd0;
            cnt          <= '0;
            digits_q     <= 16'h0000;
            dp_q         <= 4'h0;
            blank_q      <= 4'h0;
            frame_done_q <= 1'b0;
        end else if (!bus.en) begin
            state        <= ST_LOAD;
            idx          <= 2'd0;
            cnt          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    digits_q     <= bus.digits_in;
                    dp_q         <= bus.dp_in;
                    blank_q      <= cap_blank;
                    idx          <= 2'd0;
                    cnt          <= '0;
                    frame_done_q <= 1'b1;
                    state        <= ST_SHOW;
                end
                ST_SHOW: begin
                    frame_done_q <= 1'b0;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (idx == 2'd3) begin
                        digits_q     <= bus.digits_in;
                        dp_q         <= bus.dp_in;
                        blank_q      <= cap_blank;
                        idx          <= 2'd0;
                        frame_done_q <= 1'b1;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                    state <= ST_SHOW;
                end
                default: begin
                    state        <= ST_LOAD;
                    idx          <= 2'd0;
                    cnt          <= '0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Display outputs: dark unless enabled, out of reset and in SHOW; the blanked digit keeps its anode.
    always_comb begin
        logic       lit;
        logic [3:0] code;
        lit           = rst_n && bus.en && (state == ST_SHOW);
        code          = digits_q[{idx, 2'b00} +: 4];
        bus.an_out    = 4'hF;
        bus.seg_out   = 7'h7F;
        bus.dp_out    = 1'b1;
        if (lit) begin
            bus.an_out = ~(4'b0001 << idx);
            if (!blank_q[idx]) begin
                bus.seg_out = ~decode(code);
                bus.dp_out  = ~dp_q[idx];
            end
        end
        bus.digit_idx  = idx;
        bus.frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with CLK_DIV=4.
// The reference model tracks the position inside the frame as a plain cycle
// count. The slot, the lit/dark phase and the expected outputs all come from
// that count.
module tb_seg7_scan_driver;

    localparam int D     = 4;
    localparam int FRAME = 4 * (D + 1);
    localparam logic [6:0] SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.CLK_DIV(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame position and snapshot contents
    bit          m_active = 1'b0;
    int          m_t      = 0;
    logic [15:0] m_dig    = 16'h0;
    logic [3:0]  m_dp     = 4'h0;
    logic [3:0]  m_blank  = 4'h0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_capture();
        m_dig   = bus.digits_in;
        m_dp    = bus.dp_in;
        m_blank = bus.blank_in;
        if (LZB) begin
            for (int i = 3; i >= 1; i--) begin
                if (m_dig[i*4 +: 4] != 4'd0 || m_dp[i]) break;
                m_blank[i] = 1'b1;
            end
        end
    endtask

    task automatic model_step();
        if (!rst_n || !bus.en) begin
            m_active = 1'b0;
            m_t      = 0;
        end else if (!m_active) begin
            model_capture();
            m_active = 1'b1;
            m_t      = 0;
        end else begin
            m_t++;
            if (m_t == FRAME) begin
                m_t = 0;
                model_capture();
            end
        end
    endtask

    task automatic check_model(input string tag);
        int         slot;
        int         off;
        bit         lit;
        bit         show;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        slot  = m_t / (D + 1);
        off   = m_t % (D + 1);
        lit   = rst_n && bus.en && m_active && (off < D);
        show  = lit && !m_blank[slot];
        e_an  = lit ? ~(4'b0001 << slot) : 4'hF;
        e_seg = show ? ~SEG_ON[m_dig[slot*4 +: 4]] : 7'h7F;
        e_dp  = (show && m_dp[slot]) ? 1'b0 : 1'b1;
        chk({tag, ".an"},  16'(bus.an_out),  16'(e_an));
        chk({tag, ".seg"}, 16'(bus.seg_out), 16'(e_seg));
        chk({tag, ".dp"},  16'(bus.dp_out),  16'(e_dp));
        chk({tag, ".idx"}, 16'(bus.digit_idx), m_active ? 16'(slot) : 16'd0);
        chk({tag, ".fd"},  16'(bus.frame_done), 16'(m_active && m_t == 0));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        bus.en        = 1'b0;
        bus.digits_in = 16'h0000;
        bus.dp_in     = 4'h0;
        bus.blank_in  = 4'h0;

        // Reset
        repeat (2) tick("rst");

        // Basic scan of 1234
        rst_n = 1'b1;
        bus.en = 1'b1;
        bus.digits_in = 16'h1234;
        #1;
        check_model("load");
        chk("load_an", 16'(bus.an_out), 16'h000F);
        tick("s1");
        chk("s1_an0", 16'(bus.an_out), 16'h000E);
        chk("s1_seg0", 16'(bus.seg_out), 16'h0019);
        chk("s1_fd", 16'(bus.frame_done), 16'h0001);
        repeat (3) tick("s1");
        chk("s1_fd_low", 16'(bus.frame_done), 16'h0000);
        chk("s1_an0_last", 16'(bus.an_out), 16'h000E);
        tick("s1");
        chk("s1_gap", 16'(bus.an_out), 16'h000F);
        tick("s1");
        chk("s1_an1", 16'(bus.an_out), 16'h000D);
        chk("s1_seg1", 16'(bus.seg_out), 16'h0030);

        // Change inputs mid-digit1: current frame must not tear
        tick("tear");
        bus.digits_in = 16'h5678;
        repeat (4) tick("tear");
        chk("tear_d2", 16'(bus.seg_out), 16'h0024);
        repeat (10) tick("tear");
        chk("new_fd", 16'(bus.frame_done), 16'h0001);
        chk("new_d0", 16'(bus.seg_out), 16'h0000);

        // Dash codes, forced blank and decimal point
        bus.digits_in = 16'hF00A;
        bus.blank_in  = 4'b0100;
        bus.dp_in     = 4'b0001;
        repeat (20) tick("dash");
        chk("dash_d0", 16'(bus.seg_out), 16'h003F);
        chk("dash_dp0", 16'(bus.dp_out), 16'h0000);
        repeat (10) tick("dash");
        chk("blank_an2", 16'(bus.an_out), 16'h000B);
        chk("blank_seg2", 16'(bus.seg_out), 16'h007F);
        repeat (5) tick("dash");
        chk("dash_d3", 16'(bus.seg_out), 16'h003F);

        // Enable dropped during digit2, held low for 10 cycles
        repeat (15) tick("en");
        bus.en = 1'b0;
        #1;
        check_model("en_comb");
        chk("en_comb_an", 16'(bus.an_out), 16'h000F);
        repeat (10) tick("en_low");
        chk("en_low_an", 16'(bus.an_out), 16'h000F);
        chk("en_low_idx", 16'(bus.digit_idx), 16'h0000);
        bus.en = 1'b1;
        #1;
        check_model("en_load");
        tick("en_restart");
        chk("en_restart_an", 16'(bus.an_out), 16'h000E);
        chk("en_restart_fd", 16'(bus.frame_done), 16'h0001);

        // Reset pulse during digit3
        repeat (15) tick("rst_mid");
        rst_n = 1'b0;
        tick("rst_mid");
        chk("rst_mid_an", 16'(bus.an_out), 16'h000F);
        chk("rst_mid_fd", 16'(bus.frame_done), 16'h0000);
        chk("rst_mid_idx", 16'(bus.digit_idx), 16'h0000);
        rst_n = 1'b1;
        bus.digits_in = 16'h1234;
        bus.blank_in  = 4'h0;
        bus.dp_in     = 4'h0;
        tick("rst_restart");
        chk("rst_restart_an", 16'(bus.an_out), 16'h000E);
        chk("rst_restart_seg", 16'(bus.seg_out), 16'h0019);
        chk("rst_restart_fd", 16'(bus.frame_done), 16'h0001);

        // Leading zeros (blanked only when the option is built in)
        bus.digits_in = 16'h0040;
        repeat (20) tick("lz");
        chk("lz_d0", 16'(bus.seg_out), 16'h0040);
        repeat (5) tick("lz");
        chk("lz_d1", 16'(bus.seg_out), 16'h0019);
        repeat (5) tick("lz");
        chk("lz_d2", 16'(bus.seg_out), LZB ? 16'h007F : 16'h0040);
        repeat (5) tick("lz");
        chk("lz_d3", 16'(bus.seg_out), LZB ? 16'h007F : 16'h0040);
        bus.dp_in = 4'b0100;
        repeat (15) tick("lzdp");
        chk("lzdp_d2", 16'(bus.seg_out), 16'h0040);
        chk("lzdp_dp2", 16'(bus.dp_out), 16'h0000);
        repeat (5) tick("lzdp");
        chk("lzdp_d3", 16'(bus.seg_out), LZB ? 16'h007F : 16'h0040);

        // Randomized inputs, enable drops and reset pulses
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 299));
            rst_n  = (r != 0);
            bus.en = !(r >= 1 && r <= 6);
            if ($urandom_range(0, 5) == 0) begin
                for (int i = 0; i < 4; i++) begin
                    bus.digits_in[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                end
                bus.dp_in    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                bus.blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
